// File: rtl/ctrl_pipe_pkg.sv
// Shared widths, field positions and stage-register layouts
// for the pipelined control carrier.
package pipe_ctrl_pkg;

  localparam int WB_W   = 2;
  localparam int M_W    = 3;
  localparam int EX_W   = 4;
  localparam int ALUC_W = 4;
  localparam int REG_W  = 5;

  localparam int RW_B   = 1;
  localparam int MTR_B  = 0;
  localparam int BR_B   = 2;
  localparam int MR_B   = 1;
  localparam int MW_B   = 0;
  localparam int RD_B   = 3;
  localparam int AOP_HI = 2;
  localparam int AOP_LO = 1;
  localparam int ASRC_B = 0;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [EX_W-1:0]   ex;
    logic [ALUC_W-1:0] aluc;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              valid;
  } idex_t;

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [M_W-1:0]   m;
    logic [REG_W-1:0] wreg;
    logic             valid;
  } exmem_t;

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] wreg;
    logic             valid;
  } memwb_t;

endpackage

// File: rtl/ctrl_pipe_stage_reg.sv
// Generic pipeline register: async reset, hold has
// priority over the synchronous clear-to-bubble.
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Freeze on hold, otherwise load a bubble or the next value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (!hold)
      q <= clr ? '0 : d;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline ID/EX -> EX/MEM -> MEM/WB with
// load-use stall, flush, hold, forwarding and stall count.
import pipe_ctrl_pkg::*;

module ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       id_wb,
  input  logic [2:0]       id_m,
  input  logic [3:0]       id_ex,
  input  logic [3:0]       id_aluctrl,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_valid,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic [3:0]       ex_ex,
  output logic [3:0]       ex_aluctrl,
  output logic [4:0]       ex_wreg,
  output logic [2:0]       mem_m,
  output logic [4:0]       mem_wreg,
  output logic [1:0]       wb_wb,
  output logic [4:0]       wb_wreg,
  output logic             stall_o,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  idex_t  idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  logic   lu_hit;

  // Next-state bundles for each stage register.
  always_comb begin
    idex_d       = '0;
    idex_d.wb    = id_wb;
    idex_d.m     = id_m;
    idex_d.ex    = id_ex;
    idex_d.aluc  = id_aluctrl;
    idex_d.rs    = id_rs;
    idex_d.rt    = id_rt;
    idex_d.rd    = id_rd;
    idex_d.valid = id_valid;
    exmem_d       = '0;
    exmem_d.wb    = idex_q.wb;
    exmem_d.m     = idex_q.m;
    exmem_d.wreg  = ex_wreg;
    exmem_d.valid = idex_q.valid;
    memwb_d       = '0;
    memwb_d.wb    = exmem_q.wb;
    memwb_d.wreg  = exmem_q.wreg;
    memwb_d.valid = exmem_q.valid;
  end

  ctrl_stage_reg #(.W($bits(idex_t))) u_idex (
    .clk  (clk),
    .rst  (rst),
    .hold (hold_i),
    .clr  (flush_i | stall_o),
    .d    (idex_d),
    .q    (idex_q)
  );

  ctrl_stage_reg #(.W($bits(exmem_t))) u_exmem (
    .clk  (clk),
    .rst  (rst),
    .hold (hold_i),
    .clr  (flush_i),
    .d    (exmem_d),
    .q    (exmem_q)
  );

  ctrl_stage_reg #(.W($bits(memwb_t))) u_memwb (
    .clk  (clk),
    .rst  (rst),
    .hold (hold_i),
    .clr  (1'b0),
    .d    (memwb_d),
    .q    (memwb_q)
  );

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input exmem_t     em,
    input memwb_t     mw
  );
    logic em_hit, mw_hit;
    em_hit = em.wb[RW_B] & em.valid &
             (em.wreg != '0) & (em.wreg == src);
    mw_hit = mw.wb[RW_B] & mw.valid &
             (mw.wreg != '0) & (mw.wreg == src);
    if (em_hit)
      return FWD_EXMEM;
    else if (mw_hit)
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

  // Load-use detection, flush masking and forwarding selects.
  always_comb begin
    lu_hit  = idex_q.m[MR_B] & idex_q.valid &
              (idex_q.rt != '0) & id_valid &
              ((idex_q.rt == id_rs) | (idex_q.rt == id_rt));
    stall_o = lu_hit & ~flush_i;
    fwd_a   = fwd_sel(idex_q.rs, exmem_q, memwb_q);
    fwd_b   = fwd_sel(idex_q.rt, exmem_q, memwb_q);
  end

  // Stage outputs delivered to each consumer.
  always_comb begin
    ex_ex      = idex_q.ex;
    ex_aluctrl = idex_q.aluc;
    ex_wreg    = idex_q.ex[RD_B] ? idex_q.rd : idex_q.rt;
    mem_m      = exmem_q.m;
    mem_wreg   = exmem_q.wreg;
    wb_wb      = memwb_q.wb;
    wb_wreg    = memwb_q.wreg;
  end

  // Count inserted bubbles, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (!hold_i && stall_o && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control-signal carrier for the 5-stage CPU. Consumes the per-instruction WB/M/EX/ALUCtrl bundles produced by the ID-stage decoder and delivers each field to the stage that uses it, through the ID/EX, EX/MEM and MEM/WB registers. Also owns load-use hazard detection (bubble insertion), flush and global hold handling, forwarding-select generation and a stall counter. Sits between the ID-stage decoder and the EX/MEM/WB datapath.

## Interface
- `CNT_W`, default 16: width of the stall counter.
- `clk` in 1: single clock; all registers update on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_wb` in 2: {RegWrite, MemtoReg}.
- `id_m` in 3: {Branch, MemRead, MemWrite}.
- `id_ex` in 4: {RegDst, ALUOp[1:0], ALUSrc}.
- `id_aluctrl` in 4: ALU function code.
- `id_rs`, `id_rt`, `id_rd` in 5 each: register fields of the ID instruction.
- `id_valid` in 1: ID holds a real instruction.
- `hold_i` in 1: global freeze, e.g. memory wait.
- `flush_i` in 1: branch taken, resolved in MEM.
- `ex_ex`, `ex_aluctrl` out 4 each: EX-stage controls.
- `ex_wreg` out 5: EX destination, RegDst ? rd : rt.
- `mem_m` out 3: MEM-stage controls.
- `mem_wreg` out 5.
- `wb_wb` out 2: WB-stage controls.
- `wb_wreg` out 5.
- `stall_o` out 1: hold PC and IF/ID; combinational.
- `fwd_a`, `fwd_b` out 2: ALU operand source. 00 = regfile, 10 = EX/MEM, 01 = MEM/WB.
- `stall_cnt` out CNT_W: saturating count of bubble cycles.

## Operation
- ID/EX captures wb, m, ex, aluctrl, rs, rt, rd and valid. EX/MEM captures wb, m, wreg and valid. MEM/WB captures wb, wreg and valid.
- **Load-use:** `stall_o` = idex.MemRead & idex.valid & (idex.rt != 0) & id_valid & (idex.rt == id_rs | idex.rt == id_rt).
  - On a stall edge, ID/EX loads a bubble: all control bits 0, valid 0.
  - EX/MEM and MEM/WB advance normally.
- **Flush:** when `flush_i` is high, ID/EX and EX/MEM load bubbles. MEM/WB advances normally. `stall_o` is forced to 0.
- **Hold:** when `hold_i` is high, all three registers keep their contents. `stall_cnt` does not increment.
- **Priority:** hold > flush > load-use stall > normal advance.
  - A flush raised during hold takes effect on the first edge after hold drops.
  - The source keeps `flush_i` asserted until then.
- **Forwarding for `fwd_a` (rs of ID/EX):**
  - 10 if exmem.RegWrite & exmem.valid & exmem.wreg != 0 & exmem.wreg == idex.rs.
  - Otherwise 01 under the same test against MEM/WB.
  - Otherwise 00.
  - EX/MEM has precedence when both match.
- `fwd_b` uses the same rules against idex.rt.
- Register 0 never forwards and never causes a stall.
- **Stall counter:** `stall_cnt` increments on each edge where a load-use bubble is inserted, i.e. `stall_o` high and no hold and no flush. It saturates at all-ones.

## Timing
- Reset: every output register and valid bit is 0, including `stall_cnt`.
- Consequences of reset: `stall_o`=0 and `fwd_a`=`fwd_b`=00.
- Latency: ID inputs sampled at edge N appear on the ex_* outputs after N, mem_* after N+1, wb_* after N+2 (no hold).
- `stall_o`, `fwd_a` and `fwd_b` are combinational from register state plus ID inputs, valid in the same cycle.
- A load-use stall lasts exactly one cycle: the bubble clears idex.MemRead, so `stall_o` drops in the next cycle.
- Back-to-back dependent loads produce one bubble each.
- Reset asserted mid-operation clears all stages immediately; in-flight instructions are discarded.

## Structure
- `pipe_ctrl_pkg` holds:
  - bundle widths (WB_W=2, M_W=3, EX_W=4, ALUC_W=4, REG_W=5);
  - bit-position constants for RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUOp and ALUSrc;
  - forwarding encodings FWD_RF, FWD_EXMEM, FWD_MEMWB.
- One sub-module, `ctrl_stage_reg`: parameterized width, with async reset, hold enable and synchronous clear-to-bubble. It is instantiated three times.
- Hazard and forwarding logic stay in `ctrl_pipe`.

## Test plan
- **Reset and pass-through:** release rst, issue add with RegWrite=1, RegDst=1, rd=5. Expect ex_wreg=5 after 1 edge, mem_wreg=5 after 2, wb_wb=10 and wb_wreg=5 after 3.
- **Load-use:** lw into rt=8, then an instruction with rs=8. Expect stall_o=1 for exactly one cycle, ex_ex=0000 in the bubble cycle, and stall_cnt=1.
- **Forwarding precedence:** add to r3, add to r3, then an instruction using rs=3. Expect fwd_a=10. With only the older writer present, expect fwd_a=01. With the destination r0, expect fwd_a=00.
- **Flush:** assert flush_i for one cycle while a stall condition is present. Expect stall_o=0, ID/EX and EX/MEM bubbled, MEM/WB advanced, and stall_cnt unchanged.
- **Hold:** assert hold_i for 3 cycles mid-stream, with flush_i also high. Expect all outputs frozen and no counter change. The flush is applied on the first edge after hold drops.
- **Async reset:** pulse rst mid-stream between edges. Expect all outputs 0 immediately, without waiting for a clock edge.
